// File: rtl/game_sprite_motion.sv
// game_sprite_motion: per-sprite position/velocity register with frame-divided
// motion stepping, on-screen flag and raster hit test.
// Optional build macro: GAME_SPRITE_HIT_REG_EN -- when defined, sprite_hit is
// registered (one cycle behind pixel_x/pixel_y); otherwise it is combinational.
module game_sprite_motion #(
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 10,
  parameter int unsigned D_WIDTH    = 4,
  parameter logic [X_WIDTH-1:0] START_X = '0,
  parameter logic [Y_WIDTH-1:0] START_Y = '0,
  parameter logic signed [D_WIDTH-1:0] START_DX = 1,
  parameter logic signed [D_WIDTH-1:0] START_DY = 0,
  parameter int unsigned SPRITE_W   = 8,
  parameter int unsigned SPRITE_H   = 8,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned UPDATE_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_strobe,
  input  logic [X_WIDTH-1:0] pixel_x,
  input  logic [Y_WIDTH-1:0] pixel_y,
  input  logic               write_xy,
  input  logic               write_dxy,
  input  logic               enable_update,
  output logic [X_WIDTH-1:0] sprite_x,
  output logic [Y_WIDTH-1:0] sprite_y,
  output logic               within_screen,
  output logic               sprite_hit
);

  // Frame counter needs at least one bit even when every frame steps.
  localparam int unsigned FCNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(UPDATE_DIV - 1);
  localparam int unsigned X_LIM = SCREEN_W - SPRITE_W;
  localparam int unsigned Y_LIM = SCREEN_H - SPRITE_H;

  logic [X_WIDTH-1:0]        x_r, x_nxt;
  logic [Y_WIDTH-1:0]        y_r, y_nxt;
  logic signed [D_WIDTH-1:0] dx_r, dx_nxt;
  logic signed [D_WIDTH-1:0] dy_r, dy_nxt;
  logic [FCNT_W-1:0]         fcnt_r, fcnt_nxt;
  logic                      within_r, within_nxt;
  logic                      step_c;
  logic [X_WIDTH-1:0]        dx_ext_c;
  logic [Y_WIDTH-1:0]        dy_ext_c;
  logic [X_WIDTH:0]          x_end_c;
  logic [Y_WIDTH:0]          y_end_c;
  logic                      hit_c;

  // Next-state: position load beats step; velocity load never blocks a step.
  always_comb begin
    x_nxt      = x_r;
    y_nxt      = y_r;
    dx_nxt     = dx_r;
    dy_nxt     = dy_r;
    fcnt_nxt   = fcnt_r;
    dx_ext_c   = X_WIDTH'(dx_r);
    dy_ext_c   = Y_WIDTH'(dy_r);
    step_c     = frame_strobe & enable_update & ~write_xy & (fcnt_r == FCNT_LAST);
    within_nxt = (32'(x_r) <= X_LIM) && (32'(y_r) <= Y_LIM);

    if (write_dxy) begin
      dx_nxt = START_DX;
      dy_nxt = START_DY;
    end

    if (write_xy) begin
      x_nxt    = START_X;
      y_nxt    = START_Y;
      fcnt_nxt = '0;
    end else if (!enable_update) begin
      fcnt_nxt = '0;
    end else if (step_c) begin
      x_nxt    = x_r + dx_ext_c;
      y_nxt    = y_r + dy_ext_c;
      fcnt_nxt = '0;
    end else if (frame_strobe) begin
      fcnt_nxt = fcnt_r + FCNT_W'(1);
    end
  end

  // State registers with asynchronous reset; velocity starts at rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r      <= START_X;
      y_r      <= START_Y;
      dx_r     <= '0;
      dy_r     <= '0;
      fcnt_r   <= '0;
      within_r <= 1'b1;
    end else begin
      x_r      <= x_nxt;
      y_r      <= y_nxt;
      dx_r     <= dx_nxt;
      dy_r     <= dy_nxt;
      fcnt_r   <= fcnt_nxt;
      within_r <= within_nxt;
    end
  end

  // Box test; end bounds carry an extra bit so the right/bottom edge never wraps.
  always_comb begin
    x_end_c = {1'b0, x_r} + (X_WIDTH+1)'(SPRITE_W);
    y_end_c = {1'b0, y_r} + (Y_WIDTH+1)'(SPRITE_H);
    hit_c   = (pixel_x >= x_r) && ({1'b0, pixel_x} < x_end_c) &&
              (pixel_y >= y_r) && ({1'b0, pixel_y} < y_end_c);
  end

`ifdef GAME_SPRITE_HIT_REG_EN
  logic hit_r;

  // Registered hit: one cycle behind the raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_r <= 1'b0;
    else       hit_r <= hit_c;
  end

  assign sprite_hit = hit_r;
`else
  assign sprite_hit = hit_c;
`endif

  assign sprite_x      = x_r;
  assign sprite_y      = y_r;
  assign within_screen = within_r;

endmodule

// File: doc/game_sprite_motion.md
# game_sprite_motion

Sprite-side responder for the game's master controller. It accepts the position-load (`write_xy`), velocity-load (`write_dxy`) and motion-enable (`enable_update`) controls. It steps the sprite position once per N video frames and reports `within_screen` and a per-pixel `sprite_hit` back to the game logic. One instance is used per sprite (target, torpedo); collision is the AND of two instances' `sprite_hit`.

## Interface
- `X_WIDTH`, 10, width of x position and pixel_x
- `Y_WIDTH`, 10, width of y position and pixel_y
- `D_WIDTH`, 4, signed velocity width
- `START_X`, 0, x loaded by write_xy and reset
- `START_Y`, 0, y loaded by write_xy and reset
- `START_DX`, 1, signed dx loaded by write_dxy
- `START_DY`, 0, signed dy loaded by write_dxy
- `SPRITE_W`, 8, sprite width in pixels (≥1)
- `SPRITE_H`, 8, sprite height in pixels (≥1)
- `SCREEN_W`, 640, visible width
- `SCREEN_H`, 480, visible height
- `UPDATE_DIV`, 2, frames per position step (≥1)

Ports:
- `clk` input 1: clock
- `reset` input 1: asynchronous, active-high
- `frame_strobe` input 1: one-cycle pulse per video frame
- `pixel_x` input X_WIDTH: current raster x
- `pixel_y` input Y_WIDTH: current raster y
- `write_xy` input 1: load START_X/START_Y
- `write_dxy` input 1: load START_DX/START_DY
- `enable_update` input 1: allow motion
- `sprite_x` output X_WIDTH: current x (top-left)
- `sprite_y` output Y_WIDTH: current y (top-left)
- `within_screen` output 1: sprite fully on screen
- `sprite_hit` output 1: pixel_x/pixel_y inside sprite box

## Operation
- Registers: x, y, signed dx, dy, frame counter `fcnt` (0..UPDATE_DIV-1), within_screen, sprite_hit.
- Reset values: x=START_X, y=START_Y, dx=0, dy=0, fcnt=0, within_screen=1, sprite_hit=0.
- Priority per cycle:
  - `write_xy` loads x, y and clears fcnt. Any step in the same cycle is suppressed.
  - `write_dxy` loads dx, dy. It does not suppress a step; a step taken in the same cycle uses the old dx/dy.
- Step condition: `frame_strobe & enable_update & ~write_xy & fcnt==UPDATE_DIV-1`. On a step, x += sext(dx), y += sext(dy), fcnt=0.
- `frame_strobe & enable_update` without a step increments fcnt.
- `enable_update` low clears fcnt, so motion always resumes with a full UPDATE_DIV-frame wait.
- Arithmetic is modulo 2^X_WIDTH / 2^Y_WIDTH; dx and dy are sign-extended. Moving left past 0 wraps to a large x, which reads as off-screen.
- within_screen = `x <= SCREEN_W-SPRITE_W && y <= SCREEN_H-SPRITE_H`, unsigned compare.
- sprite_hit = `pixel_x >= x && pixel_x < x+SPRITE_W && pixel_y >= y && pixel_y < y+SPRITE_H`. Bounds are computed one bit wider, so there is no wrap at the right edge.

## Timing
- Loads and steps take effect on sprite_x/sprite_y at the next clock edge.
- within_screen is registered from the current x/y. It lags sprite_x/sprite_y by one cycle: 2 cycles after the load or step edge.
- sprite_hit: see Configuration.
- UPDATE_DIV=1: a step on every strobe while enabled.
- A strobe coinciding with write_xy causes no step and leaves fcnt=0.
- Reset mid-motion returns all registers to reset values immediately (asynchronous). Velocity is 0 until the next write_dxy.

## Configuration
- `GAME_SPRITE_HIT_REG_EN`:
  - Defined: sprite_hit is registered. It reflects the pixel_x/pixel_y from one cycle earlier; the raster pipeline compensates for this.
  - Undefined: sprite_hit is combinational from pixel_x/pixel_y and x/y, with zero latency. The sprite_hit reset value then follows x/y.

## Test plan
- Reset with START_X=100, START_Y=50 -> sprite_x=100, sprite_y=50, within_screen=1, sprite_hit=0. Strobes with enable_update=1 but no write_dxy cause no motion.
- write_dxy (dx=1, dy=0), enable_update=1, UPDATE_DIV=2, 6 strobes -> x steps 100→101→102→103, one step on every 2nd strobe.
- START_X=0, dx=-1, one step -> x=1023. within_screen falls 2 edges after the step.
- write_xy asserted in the same cycle as a step-qualifying strobe -> x=START_X with no step, fcnt=0. The next step comes UPDATE_DIV strobes later.
- enable_update dropped after 1 of 2 strobes, then raised -> the next step needs 2 further strobes.
- Raster sweep with x=100, y=50, SPRITE_W=SPRITE_H=8 -> sprite_hit high exactly for pixel_x 100..107 and pixel_y 50..57. The hit appears at pixel_x=100 with 1 cycle latency when GAME_SPRITE_HIT_REG_EN is defined, and with zero latency otherwise.
